// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back stage: RV32I opcodes,
// load funct3 encodings, FSM states and error codes.
package wb_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    function automatic logic load_f3_defined(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/wb_unit_load_extend.sv
// Combinational load-data extraction: picks the byte/half/word addressed by
// off out of an aligned memory word and sign- or zero-extends it.
module load_extend
    import wb_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel   = byte_lane[off];
        half_sel   = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        data       = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data = {24'h000000, byte_sel};
            F3_LH: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = off[0];
            end
            F3_LHU: begin
                data       = {16'h0000, half_sel};
                misaligned = off[0];
            end
            F3_LW: begin
                data       = mem_rdata;
                misaligned = (off != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: latches the retiring instruction and its result, holds the
// register-file write until wb_comp (or a timeout), then pulses done.
module wb_unit
    import wb_pkg::*;
#(
    parameter int WAIT_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] inst,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] pc,
    input  logic        wb_comp,
    output logic [31:0] rf_inst,
    output logic [31:0] rf_wrdata,
    output logic        rf_wb,
    output logic        rf_regwr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   inst_reg, inst_next;
    logic [31:0]   wrdata_reg, wrdata_next;
    logic [1:0]    err_code_reg, err_code_next;

    logic [31:0] ld_data;
    logic        ld_misaligned;
    logic        calc_write;
    logic [31:0] calc_data;
    logic [1:0]  calc_err;

    load_extend u_load_extend (
        .mem_rdata  (mem_rdata),
        .funct3     (inst[14:12]),
        .off        (alu_result[1:0]),
        .data       (ld_data),
        .misaligned (ld_misaligned)
    );

    // Decode is done on the incoming word; it is only consumed at the start
    // edge, so it equals decoding the value that gets latched.
    always_comb begin
        calc_write = 1'b0;
        calc_data  = '0;
        calc_err   = ERR_NONE;
        case (inst[6:0])
            OPC_LOAD: begin
                if (ld_misaligned) begin
                    calc_err = ERR_MISALIGN;
                end else if (load_f3_defined(inst[14:12])) begin
                    calc_write = 1'b1;
                    calc_data  = ld_data;
                end
            end
            OPC_JAL, OPC_JALR: begin
                calc_write = 1'b1;
                calc_data  = pc + 32'd4;
            end
            OPC_LUI: begin
                calc_write = 1'b1;
                calc_data  = {inst[31:12], 12'h000};
            end
            OPC_OP, OPC_OP_IMM, OPC_AUIPC: begin
                calc_write = 1'b1;
                calc_data  = alu_result;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        inst_next     = inst_reg;
        wrdata_next   = wrdata_reg;
        err_code_next = err_code_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    inst_next     = inst;
                    wrdata_next   = calc_data;
                    err_code_next = calc_err;
                    cnt_next      = '0;
                    state_next    = calc_write ? WRITE : DONE;
                end
            end
            WRITE: begin
                if (wb_comp) begin
                    state_next = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next    = DONE;
                    err_code_next = ERR_TIMEOUT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            inst_reg     <= '0;
            wrdata_reg   <= '0;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            inst_reg     <= inst_next;
            wrdata_reg   <= wrdata_next;
            err_code_reg <= err_code_next;
        end
    end

    assign rf_inst   = inst_reg;
    assign rf_wrdata = wrdata_reg;
    assign rf_wb     = (state_reg == WRITE);
    assign rf_regwr  = (state_reg == WRITE);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign err_code  = err_code_reg;
    assign err       = (err_code_reg != ERR_NONE);

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed vector table, hand-written
// reset/mid-start sequences, then randomized transactions against a model.
module tb_wb_unit;

    localparam int WAIT_MAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] pc = '0;
    logic        wb_comp = 1'b0;
    logic [31:0] rf_inst;
    logic [31:0] rf_wrdata;
    logic        rf_wb;
    logic        rf_regwr;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;

    wb_unit #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .inst       (inst),
        .alu_result (alu_result),
        .mem_rdata  (mem_rdata),
        .pc         (pc),
        .wb_comp    (wb_comp),
        .rf_inst    (rf_inst),
        .rf_wrdata  (rf_wrdata),
        .rf_wb      (rf_wb),
        .rf_regwr   (rf_regwr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: result of an instruction computed straight from the ISA rules.
    function automatic void model(input logic [31:0] i_inst, input logic [31:0] alu,
                                  input logic [31:0] mem, input logic [31:0] pcv,
                                  output bit wr, output logic [31:0] data,
                                  output logic [1:0] code);
        logic [6:0]  opc;
        logic [2:0]  f3;
        int          off;
        logic [31:0] sh;
        opc  = i_inst[6:0];
        f3   = i_inst[14:12];
        off  = int'(alu[1:0]);
        sh   = mem >> (8 * off);
        wr   = 0;
        data = '0;
        code = 2'b00;
        if (opc == 7'h03) begin
            if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 != 0)) code = 2'b01;
            else if (f3 == 3'd2 && off != 0) code = 2'b01;
            else begin
                wr = 1;
                case (f3)
                    3'd0: data = {{24{sh[7]}}, sh[7:0]};
                    3'd4: data = {24'h0, sh[7:0]};
                    3'd1: data = {{16{sh[15]}}, sh[15:0]};
                    3'd5: data = {16'h0, sh[15:0]};
                    3'd2: data = mem;
                    default: wr = 0;
                endcase
            end
        end else if (opc == 7'h6F || opc == 7'h67) begin
            wr = 1; data = pcv + 32'd4;
        end else if (opc == 7'h37) begin
            wr = 1; data = i_inst & 32'hFFFFF000;
        end else if (opc == 7'h33 || opc == 7'h13 || opc == 7'h17) begin
            wr = 1; data = alu;
        end
    endfunction

    // One transaction. The emulated register file raises wb_comp once it has
    // seen rf_wb for ack_delay cycles; a large ack_delay never acknowledges.
    task automatic run_txn(input string tag, input logic [31:0] i_inst, input logic [31:0] alu,
                           input logic [31:0] mem, input logic [31:0] pcv, input int ack_delay,
                           input bit mid_start, input bit exp_wr, input logic [31:0] exp_data,
                           input logic [1:0] exp_code);
        int cyc = 0;
        int wbn = 0;
        int done_cyc = -1;
        int exp_wbn;
        logic [31:0] data_seen = '0;
        logic [31:0] inst_seen = '0;
        logic err_seen = 1'b0;
        logic [1:0] code_seen = '0;
        bit regwr_ok = 1;
        exp_wbn = !exp_wr ? 0 : ((ack_delay + 1 <= WAIT_MAX) ? ack_delay + 1 : WAIT_MAX);
        @(negedge clk);
        inst = i_inst; alu_result = alu; mem_rdata = mem; pc = pcv;
        wb_comp = 1'b0; start = 1'b1;
        while (done_cyc < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (rf_wb) begin
                wbn++;
                if (rf_regwr !== 1'b1) regwr_ok = 0;
                data_seen = rf_wrdata;
                inst_seen = rf_inst;
                wb_comp = (wbn > ack_delay);
                if (mid_start && wbn == 2) begin
                    start = 1'b1;
                    inst  = 32'hABCDE0B7;
                end
            end else begin
                wb_comp = 1'b0;
            end
            if (done) begin
                done_cyc  = cyc;
                err_seen  = err;
                code_seen = err_code;
                if (!exp_wr) inst_seen = rf_inst;
            end
        end
        wb_comp = 1'b0;
        check({tag, " done_seen"}, 32'(done_cyc >= 0), 32'd1);
        check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_wbn + 1));
        check({tag, " rf_wb_cycles"}, 32'(wbn), 32'(exp_wbn));
        check({tag, " rf_regwr"}, 32'(regwr_ok), 32'd1);
        check({tag, " err"}, 32'(err_seen), 32'(exp_code != 2'b00));
        check({tag, " err_code"}, 32'(code_seen), 32'(exp_code));
        check({tag, " rf_inst"}, inst_seen, i_inst);
        if (exp_wr) check({tag, " rf_wrdata"}, data_seen, exp_data);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " idle_after"}, 32'(busy), 32'd0);
        check({tag, " err_held"}, 32'(err_code), 32'(exp_code));
        $display("txn %s inst=%h data=%h err_code=%0d wb_cycles=%0d done_cycle=%0d",
                 tag, i_inst, data_seen, code_seen, wbn, done_cyc);
    endtask

    typedef struct {
        string       tag;
        logic [31:0] inst;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        int          ack;
        bit          wr;
        logic [31:0] data;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{"lb_off0",    32'h00008283, 32'h00001000, 32'h800000F0, 32'h0, 1,   1, 32'hFFFFFFF0, 2'b00};
        vecs[1]  = '{"lbu_off1",   32'h0000C283, 32'h00001001, 32'h123456F8, 32'h0, 1,   1, 32'h00000056, 2'b00};
        vecs[2]  = '{"lh_off2",    32'h00009283, 32'h00001002, 32'h80011234, 32'h0, 1,   1, 32'hFFFF8001, 2'b00};
        vecs[3]  = '{"jal",        32'h000000EF, 32'h0,        32'h0, 32'h00000100, 1,   1, 32'h00000104, 2'b00};
        vecs[4]  = '{"jalr_wrap",  32'h000080E7, 32'h0,        32'h0, 32'hFFFFFFFC, 1,   1, 32'h00000000, 2'b00};
        vecs[5]  = '{"lui",        32'h123450B7, 32'h0,        32'h0, 32'h0, 1,   1, 32'h12345000, 2'b00};
        vecs[6]  = '{"add",        32'h002081B3, 32'hDEADBEEF, 32'h0, 32'h0, 1,   1, 32'hDEADBEEF, 2'b00};
        vecs[7]  = '{"lw_off2",    32'h0000A283, 32'h00001002, 32'h0, 32'h0, 1,   0, 32'h0,        2'b01};
        vecs[8]  = '{"store",      32'h0050A023, 32'h00001000, 32'h0, 32'h0, 1,   0, 32'h0,        2'b00};
        vecs[9]  = '{"ld_f3_011",  32'h0000B283, 32'h00001000, 32'h0, 32'h0, 1,   0, 32'h0,        2'b00};
        vecs[10] = '{"lhu_off1",   32'h0000D283, 32'h00001001, 32'h0, 32'h0, 1,   0, 32'h0,        2'b01};
        vecs[11] = '{"lhu_off2",   32'h0000D283, 32'h00001002, 32'h80011234, 32'h0, 1, 1, 32'h00008001, 2'b00};
        vecs[12] = '{"timeout",    32'h002081B3, 32'h00000077, 32'h0, 32'h0, 100, 1, 32'h00000077, 2'b10};
        vecs[13] = '{"addi_x0",    32'h00100013, 32'h00000001, 32'h0, 32'h0, 1,   1, 32'h00000001, 2'b00};
        vecs[14] = '{"auipc",      32'h00001297, 32'h00000055, 32'h0, 32'h0, 1,   1, 32'h00000055, 2'b00};
        vecs[15] = '{"lb_off3",    32'h00008283, 32'h00001003, 32'h7F000000, 32'h0, 1, 1, 32'h0000007F, 2'b00};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst rf_wb", 32'(rf_wb), 32'd0);
        check("rst rf_regwr", 32'(rf_regwr), 32'd0);
        check("rst rf_inst", rf_inst, 32'h0);
        check("rst rf_wrdata", rf_wrdata, 32'h0);
        check("rst err", {29'd0, err, err_code}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            run_txn(vecs[i].tag, vecs[i].inst, vecs[i].alu, vecs[i].mem, vecs[i].pc,
                    vecs[i].ack, 1'b0, vecs[i].wr, vecs[i].data, vecs[i].code);

        // start pulsed mid-WRITE must be ignored and not queued
        run_txn("mid_start", 32'h002081B3, 32'h13572468, 32'h0, 32'h0, 4, 1'b1,
                1'b1, 32'h13572468, 2'b00);
        @(negedge clk);
        check("mid_start not_queued", 32'(busy), 32'd0);

        // Reset while in WRITE: back to IDLE, no done
        @(negedge clk);
        inst = 32'h002081B3; alu_result = 32'h0BADF00D; wb_comp = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rstw in_write", 32'(rf_wb), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw rf_wb", 32'(rf_wb), 32'd0);
        check("rstw busy", 32'(busy), 32'd0);
        check("rstw done", 32'(done), 32'd0);
        check("rstw rf_wrdata", rf_wrdata, 32'h0);
        @(negedge clk);
        check("rstw no_done", 32'(done), 32'd0);
        $display("txn rst_in_write rf_wb=%0d busy=%0d done=%0d", rf_wb, busy, done);
        run_txn("after_rst", 32'h123450B7, 32'h0, 32'h0, 32'h0, 1, 1'b0, 1'b1, 32'h12345000, 2'b00);

        // Randomized transactions against the model
        begin
            logic [6:0] opcs [9] = '{7'h03, 7'h03, 7'h03, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33, 7'h23};
            int acks [6] = '{1, 2, 3, 7, 8, 20};
            for (int n = 0; n < 40; n++) begin
                logic [31:0] ri, ra, rm, rp, ed;
                bit ew;
                logic [1:0] ec;
                int ak;
                ri = $urandom;
                ri[6:0] = opcs[$urandom_range(0, 8)];
                ra = $urandom;
                rm = $urandom;
                rp = $urandom;
                ak = acks[$urandom_range(0, 5)];
                model(ri, ra, rm, rp, ew, ed, ec);
                if (ew && ak + 1 > WAIT_MAX) ec = 2'b10;
                run_txn($sformatf("rand%0d", n), ri, ra, rm, rp, ak, 1'b0, ew, ed, ec);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
